// File: rtl/vga_scanout_pkg.sv
// Shared types and default timing for the VGA scanout path (800x600@72, 4bpp packed framebuffer).
package vga_scanout_pkg;

    typedef logic [3:0] VgaColorNumber_t;
    typedef logic [7:0] VgaColor_t;

    localparam int VGA_PIXELS_PER_WORD = 8;

    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_H_FP     = 56;
    localparam int VGA_H_SYNC   = 120;
    localparam int VGA_H_BP     = 64;
    localparam int VGA_V_ACTIVE = 600;
    localparam int VGA_V_FP     = 37;
    localparam int VGA_V_SYNC   = 6;
    localparam int VGA_V_BP     = 23;

    // Pixel k of a packed word lives in bits [4k+3:4k]; pixel 0 is in the LSBs.
    function automatic VgaColorNumber_t word_nibble(input logic [31:0] word, input logic [2:0] k);
        return word[{k, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/vga_scanout_timing.sv
// Raster timing generator: horizontal/vertical counters plus the stage-0 decodes
// (active area, raw syncs, frame origin, last pixel of frame) derived from them.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic       active_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       frame_start_o,
    output logic       frame_last_o,
    output logic [2:0] sub_idx_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    // Next raster position: h wraps at end of line and carries into v, v wraps at end of frame.
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Raster position registers; reset restarts at pixel (0,0).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign active_o      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hsync_o       = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
    assign vsync_o       = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
    assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign frame_last_o  = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    assign sub_idx_o     = h_cnt_q[2:0];

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: raster timing, framebuffer fetch (one 32-bit word per 8 pixels) and a
// two-stage pixel pipeline so colour, de and syncs leave together two clocks after stage 0.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int                   H_ACTIVE  = VGA_H_ACTIVE,
    parameter int                   H_FP      = VGA_H_FP,
    parameter int                   H_SYNC    = VGA_H_SYNC,
    parameter int                   H_BP      = VGA_H_BP,
    parameter int                   V_ACTIVE  = VGA_V_ACTIVE,
    parameter int                   V_FP      = VGA_V_FP,
    parameter int                   V_SYNC    = VGA_V_SYNC,
    parameter int                   V_BP      = VGA_V_BP,
    parameter logic                 SYNC_POL  = 1'b1,
    parameter int                   FB_ADDR_W = 16,
    parameter logic [FB_ADDR_W-1:0] FB_BASE   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 fb_rd,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [31:0]          fb_rdata,
    output VgaColorNumber_t      color_number,
    output logic                 de,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start
);

    logic       active0, hs0, vs0, fs0, frame_last;
    logic [2:0] k0;
    logic       fetch;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .active_o     (active0),
        .hsync_o      (hs0),
        .vsync_o      (vs0),
        .frame_start_o(fs0),
        .frame_last_o (frame_last),
        .sub_idx_o    (k0)
    );

    // Counters sit at (0,0) during reset, which is an active fetch position; the strobe is
    // qualified with rst_n so the BRAM sees no read until reset is released.
    assign fetch = active0 && (k0 == 3'd0);
    assign fb_rd = fetch && rst_n;

    logic [FB_ADDR_W-1:0] ptr_q, ptr_d;

    // Running word pointer: advances past each fetched word, rewinds at the last pixel of a frame.
    always_comb begin
        ptr_d = ptr_q;
        if (frame_last) begin
            ptr_d = FB_BASE;
        end else if (fetch) begin
            ptr_d = ptr_q + FB_ADDR_W'(1);
        end
    end

    // Word pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= FB_BASE;
        else        ptr_q <= ptr_d;
    end

    assign fb_addr = ptr_q;

    logic        act1_q, hs1_q, vs1_q, fs1_q;
    logic [2:0]  k1_q;
    logic [31:0] word_q, word_d;

    // Sub-index 0 is the cycle the BRAM data arrives; later pixels of the word reuse the latched copy.
    assign word_d = (k1_q == 3'd0) ? fb_rdata : word_q;

    // Stage 1: delay timing decodes by one clock to line up with the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            fs1_q  <= 1'b0;
            k1_q   <= 3'd0;
            word_q <= '0;
        end else begin
            act1_q <= active0;
            hs1_q  <= hs0;
            vs1_q  <= vs0;
            fs1_q  <= fs0;
            k1_q   <= k0;
            word_q <= word_d;
        end
    end

    // Stage 2: registered outputs; colour is blanked outside active video.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de           <= 1'b0;
            color_number <= '0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            frame_start  <= 1'b0;
        end else begin
            de           <= act1_q;
            color_number <= act1_q ? word_nibble(word_d, k1_q) : '0;
            hsync        <= hs1_q ? SYNC_POL : ~SYNC_POL;
            vsync        <= vs1_q ? SYNC_POL : ~SYNC_POL;
            frame_start  <= fs1_q;
        end
    end

endmodule
